// File: rtl/readout_pkg.sv
// Shared types and helpers for the readout serializer blocks.
package readout_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Beat counter width, never narrower than one bit.
    function automatic int unsigned beat_cnt_width(input int unsigned beats);
        return (beats > 1) ? unsigned'($clog2(beats)) : 1;
    endfunction

endpackage

// File: rtl/ser_hold_buffer.sv
// One-entry valid/ready holding register that feeds the serializer shifter.
module ser_hold_buffer #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    input  logic             drain,
    output logic             load_ready,
    output logic [WIDTH-1:0] hold_q,
    output logic             hold_full
);

    // Ready depends only on stored state, so an accept and a drain can share a cycle.
    assign load_ready = !hold_full || drain;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (load_valid && load_ready) begin
            hold_q    <= data_in;
            hold_full <= 1'b1;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/output_serializer_lanes.sv
// Multi-lane parallel-to-serial readout serializer with frame-sync strobe.
module output_serializer_lanes
    import readout_pkg::*;
#(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic [LANES-1:0] data_out,
    output logic             frame_sync,
    output logic             busy
);

    localparam int unsigned BEATS = WIDTH / LANES;
    localparam int unsigned CW    = beat_cnt_width(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (WIDTH % LANES != 0) begin : g_width_check
        $error("output_serializer_lanes: WIDTH must be a multiple of LANES");
    end

    ser_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_ord;
    logic [LANES-1:0] beat_nxt;
    logic             hold_full;
    logic             last_beat;
    logic             drain;

    assign last_beat = (state_q == SHIFT) && (cnt_q == LAST_BEAT);
    assign drain     = hold_full && ((state_q == IDLE) || last_beat);
    assign busy      = (state_q == SHIFT) || hold_full;

    ser_hold_buffer #(
        .WIDTH (WIDTH)
    ) u_hold (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .data_in    (data_in),
        .load_valid (load_valid),
        .drain      (drain),
        .load_ready (load_ready),
        .hold_q     (hold_q),
        .hold_full  (hold_full)
    );

    // Bit-reverse MSB-first words at load so every beat is a plain low-to-high slice.
    always_comb begin
        hold_ord = hold_q;
        if (MSB_FIRST) begin
            hold_ord = {<<{hold_q}};
        end
    end

    assign cnt_nxt  = cnt_q + CW'(1);
    assign beat_nxt = LANES'(word_q >> (32'(cnt_nxt) * LANES));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            data_out   <= '0;
            frame_sync <= 1'b0;
        end else begin
            frame_sync <= 1'b0;
            if (drain) begin
                state_q    <= SHIFT;
                cnt_q      <= '0;
                word_q     <= hold_ord;
                data_out   <= LANES'(hold_ord);
                frame_sync <= 1'b1;
            end else if ((state_q == SHIFT) && !last_beat) begin
                cnt_q    <= cnt_nxt;
                data_out <= beat_nxt;
            end else begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                data_out <= '0;
            end
        end
    end

endmodule
